seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Programmable sequence detector for a stream of W-bit symbols; generalises the fixed 1-2-3 detector.
//  Pattern (up to L symbols), pattern length and overlap mode are runtime-loadable.
//  Flags each completed match and keeps a saturating match counter.
//  Sits on the symbol stream beside the datapath; used by pre/P1 test harnesses.
// PARAMETERS
//  W            2        symbol width (bits)
//  L            8        max pattern length (symbols), >=1
//  CW           16       match counter width
//  RST_PATTERN  16'h0039 reset pattern, W*L bits; symbol i in bits [W*i+:W], i=0 first expected (1,2,3)
//  RST_LEN      3        reset pattern length
//  RST_OVERLAP  1'b1     reset overlap mode
// PORTS
//  clk          in   1     clock, all state updates on posedge
//  reset        in   1     synchronous, active-high
//  num_valid    in   1     num carries a symbol this cycle
//  num          in   W     input symbol
//  cfg_we       in   1     load cfg_pattern/cfg_len/cfg_overlap this cycle
//  cfg_pattern  in   W*L   new pattern, same packing as RST_PATTERN
//  cfg_len      in   clog2(L+1)  new pattern length
//  cfg_overlap  in   1     1: overlapping matches counted; 0: non-overlapping
//  cnt_clr      in   1     clear match counter
//  ans          out  1     registered match pulse
//  match_cnt    out  CW    number of matches since reset/clear, saturating
// BEHAVIOUR
//  Reset (sync, reset=1 at posedge): pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP,
//   history fill=0, ans=0, match_cnt=0. Reset overrides every other input.
//  State: hist[0..L-2] last accepted symbols (hist[0] newest), fill = count of valid history
//   symbols since reset/cfg/non-overlap match, saturating at L-1.
//  Effective length: len=0 -> never matches; len>L -> clamped to L.
//  Match condition at posedge with num_valid=1 and cfg_we=0:
//   fill >= len-1 AND num == pat[len-1] AND hist[k] == pat[len-2-k] for k=0..len-2.
//  ans: 1 for the cycle after the posedge that sampled the final symbol (latency 1), else 0.
//   Back-to-back matches give ans high on consecutive cycles; num_valid=0 -> ans=0 next cycle,
//   history and fill held unchanged.
//  On accepted symbol: hist shifts in num, fill=min(fill+1,L-1); if match and overlap=0, fill=0 instead.
//  cfg_we=1: latch new config, fill=0, ans=0 next cycle; num symbol that cycle is dropped;
//   match_cnt untouched.
//  match_cnt: +1 per match, holds at 2^CW-1. cnt_clr=1 same edge as match -> match_cnt=1;
//   cnt_clr alone -> 0.
//  Default config reproduces the legacy 1-2-3 detector: e.g. 1,1,2,3 matches; 1,2,0,3 does not.
// TESTING
//  1 Reset, default cfg, num=1,2,3 (valid) -> ans=1 exactly one cycle after the '3' edge, match_cnt=1.
//  2 Default cfg, stream 1,2,1,2,3,3 -> single ans pulse after 5th symbol; 1,2,0,3 -> no pulse.
//  3 cfg pattern 1,1 len=2, overlap=1, stream 1,1,1,1 -> ans high 3 consecutive cycles, cnt=3;
//    same with overlap=0 -> 2 pulses (after 2nd and 4th), cnt=2.
//  4 Default cfg, 1,2 then num_valid=0 for 5 cycles then 3 -> ans=1 after '3'; cfg_we between 2 and 3 -> no match.
//  5 CW=2, 4 matches -> match_cnt=3 held; cnt_clr with match edge -> 1; len=0 -> no ans ever.
//  6 reset asserted mid-pattern (after 1,2) then 3 -> no ans; cfg/counter back to reset values.

Source files
------------

// File: rtl/seq_detect_param_if.sv
// Symbol-stream / configuration bundle for seq_detect_param.
//   master: drives the symbol stream, configuration load and counter clear;
//           observes the match pulse and match counter.
//   slave : the detector.
// Signals:
//   num_valid    num carries a symbol this cycle
//   num          W-bit symbol
//   cfg_we       load cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  W*L bits, symbol i in [W*i +: W], symbol 0 expected first
//   cfg_len      pattern length, 0 disables matching, values above L clamp to L
//   cfg_overlap  1: overlapping matches counted, 0: non-overlapping
//   cnt_clr      clear the match counter
//   ans          registered one-cycle match pulse
//   match_cnt    saturating count of matches
interface seq_detect_param_if #(
  parameter int W  = 2,
  parameter int L  = 8,
  parameter int CW = 16
);
  localparam int LW = $clog2(L + 1);

  logic              num_valid;
  logic [W-1:0]      num;
  logic              cfg_we;
  logic [W*L-1:0]    cfg_pattern;
  logic [LW-1:0]     cfg_len;
  logic              cfg_overlap;
  logic              cnt_clr;
  logic              ans;
  logic [CW-1:0]     match_cnt;

  modport master (
    output num_valid, num, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  ans, match_cnt
  );

  modport slave (
    input  num_valid, num, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output ans, match_cnt
  );
endinterface

// File: rtl/seq_detect_param.sv
// Programmable sequence detector for a stream of W-bit symbols.
// Pattern (up to L symbols), length and overlap mode are loadable at runtime;
// every completed match raises ans for one cycle and bumps a saturating counter.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous, active-high; overrides every other input
//   bus    seq_detect_param_if.slave (symbol stream, config, ans, match_cnt)
module seq_detect_param #(
  parameter int             W           = 2,
  parameter int             L           = 8,
  parameter int             CW          = 16,
  parameter logic [W*L-1:0] RST_PATTERN = 16'h0039,
  parameter int             RST_LEN     = 3,
  parameter bit             RST_OVERLAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detect_param_if.slave    bus
);
  localparam int LW = $clog2(L + 1);
  // History holds the L-1 symbols preceding the final one; keep one slot when L=1.
  localparam int HL = (L > 1) ? L - 1 : 1;
  localparam logic [LW-1:0] LEN_CAP  = LW'(L);
  localparam logic [LW-1:0] FILL_MAX = LW'(L - 1);

  logic [W*L-1:0] pat;
  logic [LW-1:0]  len;
  logic           overlap;
  logic [LW-1:0]  fill;
  logic [W-1:0]   hist [HL];
  logic           ans_q;
  logic [CW-1:0]  cnt_q;

  logic [LW-1:0]  eff_len;
  logic [W-1:0]   pat_sym [L];
  logic           fill_ok;
  logic           last_ok;
  logic           hist_ok;
  logic           match;

  // Pattern lookups are written as loops over constant indices so the
  // variable pattern length only ever drives compare enables, never an index.
  always_comb begin
    eff_len = (len > LEN_CAP) ? LEN_CAP : len;
    for (int i = 0; i < L; i++) begin
      pat_sym[i] = pat[W*i +: W];
    end

    fill_ok = (int'(fill) + 1) >= int'(eff_len);

    // Final symbol must equal pat[eff_len-1]; eff_len=0 leaves this false.
    last_ok = 1'b0;
    for (int i = 0; i < L; i++) begin
      if ((i + 1) == int'(eff_len) && bus.num == pat_sym[i]) begin
        last_ok = 1'b1;
      end
    end

    // hist[k] must equal pat[eff_len-2-k], i.e. k + j + 2 == eff_len.
    hist_ok = 1'b1;
    for (int k = 0; k < HL; k++) begin
      for (int j = 0; j < L; j++) begin
        if ((k + j + 2) == int'(eff_len) && hist[k] != pat_sym[j]) begin
          hist_ok = 1'b0;
        end
      end
    end

    match = bus.num_valid && !bus.cfg_we && fill_ok && last_ok && hist_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat     <= RST_PATTERN;
      len     <= LW'(RST_LEN);
      overlap <= RST_OVERLAP;
      fill    <= '0;
      for (int i = 0; i < HL; i++) begin
        hist[i] <= '0;
      end
      ans_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ans_q <= match;

      // A config load drops the symbol presented in the same cycle.
      if (bus.cfg_we) begin
        pat     <= bus.cfg_pattern;
        len     <= bus.cfg_len;
        overlap <= bus.cfg_overlap;
        fill    <= '0;
      end else if (bus.num_valid) begin
        for (int i = HL - 1; i > 0; i--) begin
          hist[i] <= hist[i-1];
        end
        hist[0] <= bus.num;
        if (match && !overlap) begin
          fill <= '0;
        end else if (fill != FILL_MAX) begin
          fill <= fill + LW'(1);
        end
      end

      // A clear coinciding with a match leaves that match counted.
      if (bus.cnt_clr) begin
        cnt_q <= match ? CW'(1) : '0;
      end else if (match && cnt_q != '1) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.ans       = ans_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param. Two instances share one stimulus stream:
// dut_a with a 16-bit counter and dut_b with a 2-bit counter (saturates at 3).
// Each driven cycle pushes its hand-computed expected ans / match count; a
// monitor pops one entry per clock after the outputs settle and compares.
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  seq_detect_param_if #(.W(2), .L(8), .CW(16)) bus_a ();
  seq_detect_param_if #(.W(2), .L(8), .CW(2))  bus_b ();

  seq_detect_param #(.W(2), .L(8), .CW(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  seq_detect_param #(.W(2), .L(8), .CW(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  typedef struct {
    int   step;
    logic ea;
    int   ec;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  logic [15:0] cur_pat = 16'h0039;
  logic [3:0]  cur_len = 4'd3;
  logic        cur_ov  = 1'b1;

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, step, act, want);
    end
  endtask

  // One clock of stimulus plus the outputs expected after that edge.
  task automatic drive(input bit r, input bit v, input logic [1:0] n, input bit we,
                       input bit clr, input bit ea, input int ec);
    exp_t e;
    @(negedge clk);
    reset = r;
    bus_a.num_valid = v;  bus_b.num_valid = v;
    bus_a.num = n;        bus_b.num = n;
    bus_a.cfg_we = we;    bus_b.cfg_we = we;
    bus_a.cfg_pattern = cur_pat;  bus_b.cfg_pattern = cur_pat;
    bus_a.cfg_len = cur_len;      bus_b.cfg_len = cur_len;
    bus_a.cfg_overlap = cur_ov;   bus_b.cfg_overlap = cur_ov;
    bus_a.cnt_clr = clr;  bus_b.cnt_clr = clr;
    step_no++;
    e.step = step_no;
    e.ea = ea;
    e.ec = ec;
    q.push_back(e);
  endtask

  task automatic sym(input logic [1:0] n, input bit ea, input int ec);
    drive(1'b0, 1'b1, n, 1'b0, 1'b0, ea, ec);
  endtask

  task automatic idle(input int ec);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, ec);
  endtask

  task automatic cfg(input logic [15:0] p, input logic [3:0] ln, input bit ov, input int ec);
    cur_pat = p;
    cur_len = ln;
    cur_ov  = ov;
    drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, ec);
  endtask

  task automatic rst(input int n);
    drive(1'b1, 1'b1, n[1:0], 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Monitor: outputs settle after the posedge, compare 2 time units later.
  initial begin
    exp_t e;
    int   sat;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        sat = (e.ec > 3) ? 3 : e.ec;
        chk("ans_a", e.step, 32'(bus_a.ans), 32'(e.ea));
        chk("cnt_a", e.step, 32'(bus_a.match_cnt), e.ec);
        chk("ans_b", e.step, 32'(bus_b.ans), 32'(e.ea));
        chk("cnt_b", e.step, 32'(bus_b.match_cnt), sat);
      end
    end
  end

  initial begin
    bus_a.num_valid = 1'b0; bus_b.num_valid = 1'b0;
    bus_a.num = '0;         bus_b.num = '0;
    bus_a.cfg_we = 1'b0;    bus_b.cfg_we = 1'b0;
    bus_a.cfg_pattern = cur_pat; bus_b.cfg_pattern = cur_pat;
    bus_a.cfg_len = cur_len;     bus_b.cfg_len = cur_len;
    bus_a.cfg_overlap = cur_ov;  bus_b.cfg_overlap = cur_ov;
    bus_a.cnt_clr = 1'b0;   bus_b.cnt_clr = 1'b0;

    // Reset state, then legacy 1,2,3.
    rst(0);
    sym(1, 0, 0); sym(2, 0, 0); sym(3, 1, 1);
    idle(1);

    // 1,2,1,2,3,3 -> one pulse after the 5th; 1,2,0,3 -> none; 1,1,2,3 -> pulse.
    sym(1, 0, 1); sym(2, 0, 1); sym(1, 0, 1); sym(2, 0, 1); sym(3, 1, 2); sym(3, 0, 2);
    sym(1, 0, 2); sym(2, 0, 2); sym(0, 0, 2); sym(3, 0, 2);
    sym(1, 0, 2); sym(1, 0, 2); sym(2, 0, 2); sym(3, 1, 3);

    // Clear alone, then pattern 1,1 overlapping: 3 consecutive pulses.
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 0);
    cfg(16'h0005, 4'd2, 1'b1, 0);
    sym(1, 0, 0); sym(1, 1, 1); sym(1, 1, 2); sym(1, 1, 3);
    // Non-overlapping: pulses after 2nd and 4th; dut_b holds at 3.
    cfg(16'h0005, 4'd2, 1'b0, 3);
    sym(1, 0, 3); sym(1, 1, 4); sym(1, 0, 4); sym(1, 1, 5);
    // Clear on the same edge as a match leaves count 1.
    sym(1, 0, 5);
    drive(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1);

    // Gap of 5 idle cycles keeps history.
    rst(0);
    sym(1, 0, 0); sym(2, 0, 0);
    idle(0); idle(0); idle(0); idle(0); idle(0);
    sym(3, 1, 1);
    // Config load between 2 and 3 (its own symbol dropped) -> no match.
    sym(1, 0, 1); sym(2, 0, 1);
    cur_pat = 16'h0039; cur_len = 4'd3; cur_ov = 1'b1;
    drive(1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1);
    sym(3, 0, 1);

    // Length 0 never matches.
    cfg(16'h0039, 4'd0, 1'b1, 1);
    sym(1, 0, 1); sym(2, 0, 1); sym(3, 0, 1); sym(3, 0, 1);

    // Length 15 clamps to 8: eight 2s give the first match, the ninth another.
    cfg(16'hAAAA, 4'd15, 1'b1, 1);
    for (int i = 0; i < 7; i++) sym(2, 0, 1);
    sym(2, 1, 2); sym(2, 1, 3);

    // Reset mid-pattern with a would-be '3' presented during reset.
    rst(0);
    sym(1, 0, 0); sym(2, 0, 0);
    rst(3);
    sym(3, 0, 0);
    // Reset restored the 1-2-3 pattern.
    sym(1, 0, 0); sym(2, 0, 0); sym(3, 1, 1);
    idle(1);

    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
